// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, taken branch, memory wait.
// Optional stall_cycles counter when PIPE_STALL_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT = 2,
  parameter int REG_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
`ifdef PIPE_STALL_CNT_EN
  output logic [15:0]      stall_cycles,
`endif
  output logic             wait_busy
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam bit         HAS_WAIT = (MEM_WAIT > 0);
  localparam logic [3:0] WAIT_LD  = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       hazard, frz_run, frz_wait;
  logic       hold, br, lu;

  assign hazard = ex_memRead && (ex_write_reg != '0) &&
                  ((ex_write_reg == id_rs) ||
                   (id_uses_rt && (ex_write_reg == id_rt)));

  assign frz_run  = HAS_WAIT && (state == S_RUN) && mem_access;
  assign frz_wait = (state == S_WAIT) && (cnt != 4'd0);

  // Mutually exclusive qualifiers encode freeze > branch > load-use.
  assign hold = rst_n && (frz_run || frz_wait);
  assign br   = rst_n && !(frz_run || frz_wait) && ex_branch_taken;
  assign lu   = rst_n && !(frz_run || frz_wait) && !ex_branch_taken
                && hazard;

  assign wait_busy = (state == S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      S_RUN: begin
        if (frz_run) begin
          next_state = S_WAIT;
          next_cnt   = WAIT_LD;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) next_cnt = cnt - 4'd1;
        else next_state = S_RUN;
      end
      default: next_state = S_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (1'b1)
      !rst_n, hold: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end
      br: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      lu: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= 16'd0;
    else if (!pc_en && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_WAIT=2, REG_W=3).
// Stall counter checks run only when PIPE_STALL_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

  typedef logic [7:0] vec_t;

  // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id_flush, id_ex_flush, wait_busy}
  localparam vec_t RST  = 8'b00000_00_0;
  localparam vec_t IDLE = 8'b11111_00_0;
  localparam vec_t FRZ  = 8'b00000_00_0;
  localparam vec_t WFRZ = 8'b00000_00_1;
  localparam vec_t REL  = 8'b11111_00_1;
  localparam vec_t LU   = 8'b00111_01_0;
  localparam vec_t BR   = 8'b11111_11_0;
  localparam vec_t RBR  = 8'b11111_11_1;
  localparam vec_t RLU  = 8'b00111_01_1;

  logic       clk, rst_n;
  logic [2:0] id_rs, id_rt, ex_write_reg;
  logic       id_uses_rt, ex_memRead, ex_branch_taken, mem_access;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, wait_busy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  vec_t  exp_q[$];
  vec_t  obs_q[$];
  string name_q[$];

  pipeline_hazard_ctrl #(.MEM_WAIT(2), .REG_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memRead(ex_memRead), .ex_write_reg(ex_write_reg),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
`ifdef PIPE_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .wait_busy(wait_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t outs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, wait_busy};
  endfunction

  task automatic sample(input string nm, input vec_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    obs_q.push_back(outs());
  endtask

  // Drive one cycle at negedge, sample just before the next posedge.
  task automatic cyc(input string nm,
                     input logic [2:0] rs, input logic [2:0] rt,
                     input logic urt, input logic mr,
                     input logic [2:0] wr, input logic br,
                     input logic ma, input vec_t e);
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_memRead = mr; ex_write_reg = wr;
    ex_branch_taken = br; mem_access = ma;
    #4;
    sample(nm, e);
  endtask

  task automatic idle_in();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memRead = 0;
    ex_write_reg = 0; ex_branch_taken = 0; mem_access = 0;
  endtask

  task automatic test_reset();
    vec_t e, o; string n;
    idle_in();
    rst_n = 1'b0;
    #1 sample("rst_async", RST);
    @(negedge clk) sample("rst_held", RST);
    rst_n = 1'b1;
    cyc("rst_first_run", 0, 0, 0, 0, 0, 0, 0, IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t e, o; string n;
    cyc("lu_rs", 3, 0, 0, 1, 3, 0, 0, LU);
    cyc("lu_clear", 3, 0, 0, 0, 3, 0, 0, IDLE);
    cyc("lu_r0_wr", 3, 0, 0, 1, 0, 0, 0, IDLE);
    cyc("lu_r0_both", 0, 0, 0, 1, 0, 0, 0, IDLE);
    cyc("lu_rt_nouse", 1, 5, 0, 1, 5, 0, 0, IDLE);
    cyc("lu_rt_use", 1, 5, 1, 1, 5, 0, 0, LU);
    cyc("lu_rt_r0", 1, 0, 1, 1, 0, 0, 0, IDLE);
    cyc("lu_miss", 2, 4, 1, 1, 6, 0, 0, IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t e, o; string n;
    cyc("mem0_frz", 0, 0, 0, 0, 0, 0, 1, FRZ);
    cyc("mem0_wait", 0, 0, 0, 0, 0, 0, 1, WFRZ);
    cyc("mem0_rel", 0, 0, 0, 0, 0, 0, 1, REL);
    cyc("mem1_frz", 0, 0, 0, 0, 0, 0, 1, FRZ);
    cyc("mem1_wait", 0, 0, 0, 0, 0, 0, 1, WFRZ);
    cyc("mem1_rel", 0, 0, 0, 0, 0, 0, 0, REL);
    cyc("mem_done", 0, 0, 0, 0, 0, 0, 0, IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_branch();
    vec_t e, o; string n;
    cyc("br_over_lu", 3, 0, 0, 1, 3, 1, 0, BR);
    cyc("br_alone", 0, 0, 0, 0, 0, 1, 0, BR);
    cyc("br_frz", 0, 0, 0, 0, 0, 1, 1, FRZ);
    cyc("br_wait", 0, 0, 0, 0, 0, 1, 0, WFRZ);
    cyc("br_rel", 0, 0, 0, 0, 0, 1, 1, RBR);
    cyc("br_after", 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("lu_frz", 3, 0, 0, 1, 3, 0, 1, FRZ);
    cyc("lu_wait", 3, 0, 0, 1, 3, 0, 0, WFRZ);
    cyc("lu_rel", 3, 0, 0, 1, 3, 0, 1, RLU);
    cyc("lu_rel_after", 0, 0, 0, 0, 0, 0, 0, IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    vec_t e, o; string n;
    cyc("rw_frz", 0, 0, 0, 0, 0, 0, 1, FRZ);
    @(negedge clk);
    idle_in();
    #1 sample("rw_cnt1", WFRZ);
    rst_n = 1'b0;
    #1 sample("rw_abort", RST);
    @(negedge clk) rst_n = 1'b1;
    #1 sample("rw_released", IDLE);
    cyc("rw_run", 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("rw_run2", 0, 0, 0, 0, 0, 0, 0, IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s got %b want %b", n, o, e);
      end
    end
  endtask

`ifdef PIPE_STALL_CNT_EN
  task automatic test_stall_cnt();
    logic [15:0] want;
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL cnt_reset got %0d want 0", stall_cycles);
    end
    @(negedge clk) rst_n = 1'b1;
    want = 16'd0;
    cyc("sc_lu", 3, 0, 0, 1, 3, 0, 0, LU);
    want += 16'd1;
    cyc("sc_idle", 0, 0, 0, 0, 0, 0, 0, IDLE);
    cyc("sc_frz", 0, 0, 0, 0, 0, 0, 1, FRZ);
    want += 16'd1;
    cyc("sc_wait", 0, 0, 0, 0, 0, 0, 0, WFRZ);
    want += 16'd1;
    cyc("sc_rel", 0, 0, 0, 0, 0, 0, 0, REL);
    cyc("sc_end", 0, 0, 0, 0, 0, 0, 0, IDLE);
    exp_q.delete(); obs_q.delete(); name_q.delete();
    checks++;
    if (stall_cycles !== want) begin
      errors++;
      $display("FAIL stall_cycles got %0d want %0d", stall_cycles, want);
    end
  endtask
`endif

  initial begin
    idle_in();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_branch();
    test_reset_in_wait();
`ifdef PIPE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
